// File: rtl/cpu_control_if.sv
// Bus between the LEGv8 control/fetch block and its environment
// (instruction memory on one side, datapath on the other).
interface cpu_control_if;
  logic [31:0] instr;
  logic        zero;
  logic        negative;
  logic        overflow;
  logic        carry_out;
  logic [63:0] pc;
  logic [4:0]  Rd;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic        Reg2Loc;
  logic        RegWrite;
  logic        MemWrite;
  logic        MemToReg;
  logic        immSel;
  logic        ALUsrc;
  logic [2:0]  ALUop;
  logic [8:0]  DAddr9;
  logic [11:0] Imm12;
  logic [3:0]  LDURBsel;
  logic [3:0]  flags_q;

  // Control block side: consumes the instruction and ALU flags, drives everything else.
  modport master (
    input  instr, zero, negative, overflow, carry_out,
    output pc, Rd, Rn, Rm, Reg2Loc, RegWrite, MemWrite, MemToReg,
           immSel, ALUsrc, ALUop, DAddr9, Imm12, LDURBsel, flags_q
  );

  // Memory/datapath side.
  modport slave (
    output instr, zero, negative, overflow, carry_out,
    input  pc, Rd, Rn, Rm, Reg2Loc, RegWrite, MemWrite, MemToReg,
           immSel, ALUsrc, ALUop, DAddr9, Imm12, LDURBsel, flags_q
  );
endinterface

// File: rtl/cpu_control.sv
// Single-cycle LEGv8 control and fetch: PC register, instruction decode,
// architectural {N,Z,V,C} flag register and zero-latency branch resolution.
module cpu_control (
  input  logic          clk,
  input  logic          reset,
  cpu_control_if.master bus
);

  logic [63:0] pc_q, pc_d;
  logic [3:0]  flg_q, flg_d;

  logic [10:0] op_s;
  logic        reg2loc_s, reg_write_s, mem_write_s, mem_to_reg_s;
  logic        imm_sel_s, alu_src_s, set_flags_s;
  logic [2:0]  alu_op_s;
  logic [3:0]  size_s;
  logic        is_b_s, is_bcond_s, is_cbz_s;

  logic        br_taken_s;
  logic [63:0] br_off_s;

  assign op_s = bus.instr[31:21];

  // Decode the opcode into datapath control strobes; anything unrecognised is a NOP.
  always_comb begin
    reg2loc_s    = 1'b1;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    imm_sel_s    = 1'b0;
    alu_src_s    = 1'b0;
    alu_op_s     = 3'b000;
    size_s       = 4'd8;
    set_flags_s  = 1'b0;
    is_b_s       = 1'b0;
    is_bcond_s   = 1'b0;
    is_cbz_s     = 1'b0;
    casez (op_s)
      11'b1001000100?: begin  // ADDI
        alu_src_s   = 1'b1;
        imm_sel_s   = 1'b1;
        alu_op_s    = 3'b010;
        reg_write_s = 1'b1;
      end
      11'b10101011000: begin  // ADDS
        alu_op_s    = 3'b010;
        reg_write_s = 1'b1;
        set_flags_s = 1'b1;
      end
      11'b11101011000: begin  // SUBS
        alu_op_s    = 3'b011;
        reg_write_s = 1'b1;
        set_flags_s = 1'b1;
      end
      11'b11111000010, 11'b00111000010: begin  // LDUR / LDURB
        alu_src_s    = 1'b1;
        alu_op_s     = 3'b010;
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        size_s       = op_s[10] ? 4'd8 : 4'd1;
      end
      11'b11111000000, 11'b00111000000: begin  // STUR / STURB
        reg2loc_s   = 1'b0;
        alu_src_s   = 1'b1;
        alu_op_s    = 3'b010;
        mem_write_s = 1'b1;
        size_s      = op_s[10] ? 4'd8 : 4'd1;
      end
      11'b000101?????: begin  // B
        is_b_s = 1'b1;
      end
      11'b01010100???: begin  // B.cond
        is_bcond_s = 1'b1;
      end
      11'b10110100???: begin  // CBZ
        is_cbz_s  = 1'b1;
        reg2loc_s = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Resolve branch direction and the sign-extended word offset.
  // B.LT looks only at the registered flags; CBZ only at this cycle's zero.
  always_comb begin
    br_taken_s = 1'b0;
    br_off_s   = 64'd4;
    if (is_b_s) begin
      br_taken_s = 1'b1;
      br_off_s   = {{38{bus.instr[25]}}, bus.instr[25:0], 2'b00};
    end else if (is_bcond_s) begin
      br_taken_s = (bus.instr[4:0] == 5'b01011) && (flg_q[3] != flg_q[1]);
      br_off_s   = {{43{bus.instr[23]}}, bus.instr[23:5], 2'b00};
    end else if (is_cbz_s) begin
      br_taken_s = bus.zero;
      br_off_s   = {{43{bus.instr[23]}}, bus.instr[23:5], 2'b00};
    end else begin
      br_taken_s = 1'b0;
      br_off_s   = 64'd4;
    end
  end

  // Next-state for PC and flags; flags only capture on ADDS/SUBS.
  always_comb begin
    pc_d  = pc_q + (br_taken_s ? br_off_s : 64'd4);
    if (set_flags_s) begin
      flg_d = {bus.negative, bus.zero, bus.overflow, bus.carry_out};
    end else begin
      flg_d = flg_q;
    end
  end

  // Architectural state: PC and flag register, synchronously cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= 64'd0;
      flg_q <= 4'd0;
    end else begin
      pc_q  <= pc_d;
      flg_q <= flg_d;
    end
  end

  // Drive the bus; write enables are suppressed while reset is held.
  assign bus.pc       = pc_q;
  assign bus.flags_q  = flg_q;
  assign bus.Rd       = bus.instr[4:0];
  assign bus.Rn       = bus.instr[9:5];
  assign bus.Rm       = bus.instr[20:16];
  assign bus.DAddr9   = bus.instr[20:12];
  assign bus.Imm12    = bus.instr[21:10];
  assign bus.Reg2Loc  = reg2loc_s;
  assign bus.RegWrite = reg_write_s & ~reset;
  assign bus.MemWrite = mem_write_s & ~reset;
  assign bus.MemToReg = mem_to_reg_s;
  assign bus.immSel   = imm_sel_s;
  assign bus.ALUsrc   = alu_src_s;
  assign bus.ALUop    = alu_op_s;
  assign bus.LDURBsel = size_s;

endmodule

// File: doc/cpu_control.md
# cpu_control

Control-and-fetch block for the single-cycle LEGv8 CPU. It drives the datapath: it holds the program counter, decodes each 32-bit instruction into the datapath's register addresses, immediates and control strobes, and keeps the architectural flag register. It also resolves branches using the datapath's returned flags. It sits between instruction memory (address out, instruction in) and the datapath (controls out, zero/negative/overflow/carry_out in).

## Interface
- No parameters. Widths are fixed: 64-bit PC and 32-bit instruction.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction word fetched from pc.
- zero, negative, overflow, carry_out  input  1 each  current-cycle ALU flags from the datapath.
- pc  output  64  instruction-memory address.
- Rd, Rn, Rm  output  5 each  register fields; Rd=instr[4:0], Rn=instr[9:5], Rm=instr[20:16], always driven.
- Reg2Loc  output  1  1 selects Rm as read port B, 0 selects Rd/Rt.
- RegWrite, MemWrite, MemToReg  output  1 each  register write enable, memory write enable, and 1 selects memory data for the writeback.
- immSel  output  1  1 selects zero-padded Imm12, 0 selects sign-extended DAddr9.
- ALUsrc  output  1  1 selects the immediate as ALU B input.
- ALUop  output  3  000 pass B, 010 add, 011 subtract.
- DAddr9  output  9  instr[20:12].
- Imm12  output  12  instr[21:10].
- LDURBsel  output  4  transfer size: 4'd8 doubleword, 4'd1 byte.
- flags_q  output  4  registered {N,Z,V,C}, for debug and branch use.

## Operation
- Decode on instr[31:21]. Instructions are listed as name: opcode bits, then control settings.
  - ADDI: [31:22]=1001000100. ALUsrc=1, immSel=1, ALUop=010, RegWrite=1.
  - ADDS: 10101011000. Reg2Loc=1, ALUop=010, RegWrite=1, sets flags.
  - SUBS: 11101011000. Same as ADDS with ALUop=011.
  - LDUR: 11111000010. ALUsrc=1, immSel=0, ALUop=010, MemToReg=1, RegWrite=1, LDURBsel=8.
  - LDURB: 00111000010. Same as LDUR with LDURBsel=1.
  - STUR: 11111000000. Reg2Loc=0, ALUsrc=1, immSel=0, ALUop=010, MemWrite=1, LDURBsel=8.
  - STURB: 00111000000. Same as STUR with LDURBsel=1.
  - B: [31:26]=000101. Unconditional branch; target = pc + (SE(instr[25:0])<<2).
  - B.cond: [31:24]=01010100, cond=instr[4:0]. Only LT (01011) is supported. Taken iff flags_q.N != flags_q.V. Any other cond is a not-taken NOP.
  - CBZ: [31:24]=10110100. Reg2Loc=0, ALUsrc=0, ALUop=000. Taken iff input zero=1. Target = pc + (SE(instr[23:5])<<2).
- Defaults for every signal not named above: RegWrite=0, MemWrite=0, MemToReg=0, Reg2Loc=1, ALUsrc=0, immSel=0, ALUop=000, LDURBsel=8.
- Any unlisted opcode is a NOP: default controls, pc+4.
- Next-PC selection:
  - Taken branch: next pc = target.
  - Otherwise: next pc = pc+4.
  - All PC arithmetic is 64-bit modulo 2^64. Negative offsets wrap correctly.
- Flag register:
  - Loads {negative, zero, overflow, carry_out} at the end of an ADDS or SUBS cycle only.
  - ADDI, loads, stores, CBZ and NOPs leave it unchanged.
- B.LT reads only the registered flags, never the current-cycle flags.
- CBZ reads only the current-cycle zero flag.

## Timing
- Single-cycle CPU: decode and next-PC logic are combinational from instr, pc, flags_q and zero.
- State is only pc and flags_q, both updated on the rising edge of clk.
- While reset=1:
  - pc <= 0 and flags_q <= 0.
  - RegWrite and MemWrite are forced to 0 regardless of instr.
- After reset deasserts, the first instruction executes from pc=0 in the first cycle with reset=0.
- Reset asserted mid-program: takes effect at that edge; there are no pending writes and no partial state.
- SUBS immediately followed by B.LT: B.LT sees the SUBS flags, because they are registered at the boundary.
- B.LT in the same cycle as the flag-setting edge uses the old value of flags_q.
- Branch to self (offset 0): pc holds its value every cycle; this is legal.
- Branch latency is zero cycles: the target is fetched in the next cycle, with no delay slot.

## Test plan
- Reset with instr=STUR encoding: pc=0, MemWrite=0, RegWrite=0, flags_q=0. After deassert, MemWrite=1 and pc goes 0 -> 4.
- ADDI X1,X31,#5 (0x910017E1): ALUsrc=1, immSel=1, ALUop=010, RegWrite=1, Imm12=5, Rd=1, Rn=31; pc advances by 4.
- SUBS with flags N=1, V=0, then B.LT offset -2 at pc=0x20:
  - flags_q becomes 4'b1000 after the SUBS edge.
  - B.LT is taken; next pc = 0x18.
- Same sequence with N=1, V=1: B.LT is not taken; pc becomes 0x24.
- CBZ X3, offset +3 at pc=0x40:
  - With zero=1: pc=0x4C.
  - With zero=0: pc=0x44.
  - Check Reg2Loc=0 and ALUop=000 in both cases.
- STURB, then B offset 0:
  - STURB: LDURBsel=1, MemWrite=1, immSel=0, DAddr9=instr[20:12].
  - B offset 0 holds pc for 3 cycles.
  - Unknown opcode 0xFFFFFFFF gives all enables 0 and pc+4.
